sort_avalon_arbiter: RTL and testbench
======================================

Name: sort_avalon_arbiter

Overview:
Packet-level round-robin arbiter that shares one sort_avalon engine between N_REQ Avalon-ST requesters. It locks a grant from a requester's SOP beat until the engine returns that packet's sorted EOP. It forwards input beats to the engine and routes the engine's output stream back to the granted requester's source port. It also enforces MAX_PKT_LEN by truncating and draining oversized packets.

Parameters:
N_REQ, 4, number of requesters (>=2)
DWIDTH, 4, data width; matches engine
MAX_PKT_LEN, 5, maximum beats per packet accepted by engine

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
snk_data_i  in  N_REQ*DWIDTH  requester input data, packed, slice i = requester i
snk_valid_i  in  N_REQ  per-requester valid
snk_startofpacket_i  in  N_REQ  per-requester SOP
snk_endofpacket_i  in  N_REQ  per-requester EOP
snk_ready_o  out  N_REQ  per-requester ready
src_data_o  out  N_REQ*DWIDTH  sorted data back to requester i
src_valid_o  out  N_REQ  per-requester output valid
src_startofpacket_o  out  N_REQ  per-requester output SOP
src_endofpacket_o  out  N_REQ  per-requester output EOP
src_ready_i  in  N_REQ  per-requester output ready
eng_snk_data_o  out  DWIDTH  data to engine sink
eng_snk_valid_o  out  1  valid to engine
eng_snk_startofpacket_o  out  1  SOP to engine
eng_snk_endofpacket_o  out  1  EOP to engine (may be forced)
eng_snk_ready_i  in  1  engine sink ready
eng_src_data_i  in  DWIDTH  engine output data
eng_src_valid_i  in  1  engine output valid
eng_src_startofpacket_i  in  1  engine output SOP
eng_src_endofpacket_i  in  1  engine output EOP
eng_src_ready_o  out  1  ready to engine
grant_o  out  N_REQ  one-hot current grant, 0 in IDLE
trunc_o  out  1  1-cycle pulse when a packet is truncated
drop_o  out  1  1-cycle pulse when a stray non-SOP beat is discarded in IDLE

Behaviour:
- Reset (async, arst_i=1): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, drain_pending=0. All outputs 0, including snk_ready_o, src_valid_o, eng_snk_valid_o, eng_src_ready_o, trunc_o, drop_o. Reset mid-packet abandons the packet; no further beats are issued.
- Transfer means valid & ready in the same cycle.
- States: IDLE, FWD_IN, WAIT_OUT.
- IDLE: winner = first i scanning rr_ptr, rr_ptr+1, ... mod N_REQ with snk_valid_i[i] & snk_startofpacket_i[i]. On a winner, register the grant and go to FWD_IN. No beat is accepted in the grant cycle (1-cycle arbitration latency). Requesters with valid & !SOP get snk_ready_o[i]=1; the beat is discarded and drop_o pulses (one pulse per cycle, OR across requesters).
- FWD_IN: combinational pass-through from requester g. eng_snk_* = snk_*[g], eng_snk_valid_o = snk_valid_i[g], snk_ready_o[g] = eng_snk_ready_i, all other snk_ready_o = 0. beat_cnt increments per transfer (width $clog2(MAX_PKT_LEN)+1).
  - Transfer with EOP: go to WAIT_OUT. A 1-beat packet (SOP & EOP) goes directly to WAIT_OUT.
  - Transfer with beat_cnt == MAX_PKT_LEN-1 and no EOP: force eng_snk_endofpacket_o=1 on that beat, set drain_pending, pulse trunc_o, go to WAIT_OUT.
- WAIT_OUT: eng_src_* are routed to src_*[g]; eng_src_ready_o = src_ready_i[g]; other src_valid_o = 0. While drain_pending=1, snk_ready_o[g]=1 and requester beats are discarded; a transfer with EOP clears drain_pending.
  - Exit to IDLE when the engine EOP transfer has occurred (latched flag out_done, or the same cycle) and drain_pending is clear (or clears the same cycle). On exit: rr_ptr = (g+1) mod N_REQ, grant=0, beat_cnt=0, out_done=0.
- src_data_o slices of non-granted requesters drive 0.
- Engine output outside WAIT_OUT is ignored (eng_src_ready_o=0). The engine never produces output before its input EOP.

Decomposition:
- sort_avalon_arb_pkg: state enum (IDLE, FWD_IN, WAIT_OUT) and a localparam function for counter width.
- One sub-module, rr_pick: combinational round-robin first-one finder. Inputs are the request vector and rr_ptr; output is a one-hot grant plus a valid flag.

Test Plan:
- Reset: assert arst_i asynchronously between clock edges -> all outputs 0 immediately, grant_o=0.
- Single requester 1 sends 3-beat packet {3,1,2} -> grant_o=4'b0010 one cycle after SOP seen; engine receives 3 beats with SOP/EOP intact; requester 1 receives sorted {1,2,3} with SOP on first and EOP on last; then IDLE.
- Requesters 0 and 2 both present SOP at the same time with rr_ptr=0 -> 0 served first, 2 served next. Requester 0 re-requests immediately -> 2 still served before 0.
- Requester 3 sends 7-beat packet, MAX_PKT_LEN=5 -> engine sees 5 beats with forced EOP on beat 5; trunc_o pulses once; beats 6-7 are accepted and dropped; IDLE only after both the drain EOP and the engine output EOP.
- Engine backpressure: eng_snk_ready_i toggles 1,0,1 and src_ready_i=0 for 2 cycles -> no beat is lost or duplicated; sorted output order is preserved.
- Stray beat: requester 1 valid without SOP in IDLE -> snk_ready_o[1]=1, drop_o pulses, no grant.

Source files
------------

// File: rtl/sort_avalon_arbiter_pkg.sv
// rtl/sort_avalon_arbiter_pkg.sv - shared types and helpers for the sort engine arbiter
package sort_avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD_IN   = 2'd1,
    WAIT_OUT = 2'd2
  } arb_state_e;

  // One extra bit so the counter can represent MAX_PKT_LEN itself.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/sort_avalon_arbiter_if.sv
// rtl/sort_avalon_arbiter_if.sv - requester, engine and status signals of the arbiter
interface sort_avalon_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DWIDTH = 4
);
  logic [N_REQ*DWIDTH-1:0] snk_data_i;
  logic [N_REQ-1:0]        snk_valid_i;
  logic [N_REQ-1:0]        snk_startofpacket_i;
  logic [N_REQ-1:0]        snk_endofpacket_i;
  logic [N_REQ-1:0]        snk_ready_o;
  logic [N_REQ*DWIDTH-1:0] src_data_o;
  logic [N_REQ-1:0]        src_valid_o;
  logic [N_REQ-1:0]        src_startofpacket_o;
  logic [N_REQ-1:0]        src_endofpacket_o;
  logic [N_REQ-1:0]        src_ready_i;
  logic [DWIDTH-1:0]       eng_snk_data_o;
  logic                    eng_snk_valid_o;
  logic                    eng_snk_startofpacket_o;
  logic                    eng_snk_endofpacket_o;
  logic                    eng_snk_ready_i;
  logic [DWIDTH-1:0]       eng_src_data_i;
  logic                    eng_src_valid_i;
  logic                    eng_src_startofpacket_i;
  logic                    eng_src_endofpacket_i;
  logic                    eng_src_ready_o;
  logic [N_REQ-1:0]        grant_o;
  logic                    trunc_o;
  logic                    drop_o;

  modport slave (
    input  snk_data_i, snk_valid_i, snk_startofpacket_i, snk_endofpacket_i,
    output snk_ready_o,
    output src_data_o, src_valid_o, src_startofpacket_o, src_endofpacket_o,
    input  src_ready_i,
    output eng_snk_data_o, eng_snk_valid_o, eng_snk_startofpacket_o, eng_snk_endofpacket_o,
    input  eng_snk_ready_i,
    input  eng_src_data_i, eng_src_valid_i, eng_src_startofpacket_i, eng_src_endofpacket_i,
    output eng_src_ready_o,
    output grant_o, trunc_o, drop_o
  );

  modport master (
    output snk_data_i, snk_valid_i, snk_startofpacket_i, snk_endofpacket_i,
    input  snk_ready_o,
    input  src_data_o, src_valid_o, src_startofpacket_o, src_endofpacket_o,
    output src_ready_i,
    input  eng_snk_data_o, eng_snk_valid_o, eng_snk_startofpacket_o, eng_snk_endofpacket_o,
    output eng_snk_ready_i,
    output eng_src_data_i, eng_src_valid_i, eng_src_startofpacket_i, eng_src_endofpacket_i,
    input  eng_src_ready_o,
    input  grant_o, trunc_o, drop_o
  );
endinterface

// File: rtl/sort_avalon_arbiter_rr_pick.sv
// rtl/sort_avalon_arbiter_rr_pick.sv - combinational round-robin first-one finder
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  // Scan starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        valid                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sort_avalon_arbiter.sv
// rtl/sort_avalon_arbiter.sv - packet-level round-robin arbiter sharing one sort engine
module sort_avalon_arbiter
  import sort_avalon_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DWIDTH      = 4,
  parameter int MAX_PKT_LEN = 5
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  sort_avalon_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_width(MAX_PKT_LEN);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]    gidx_q, rr_ptr_q, pick_idx;
  logic [CW-1:0]    beat_cnt_q;
  logic             drain_q, out_done_q;

  logic [N_REQ-1:0]  sop_req, stray, pick_gnt;
  logic              pick_vld;
  logic              g_valid, g_sop, g_eop;
  logic [DWIDTH-1:0] g_data;
  logic              at_max, in_xfer, in_last, force_eop, out_eop, drain_clr, exit_ok;

  assign sop_req = bus.snk_valid_i & bus.snk_startofpacket_i;
  assign stray   = bus.snk_valid_i & ~bus.snk_startofpacket_i;

  rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req   (sop_req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  assign g_valid = bus.snk_valid_i[gidx_q];
  assign g_sop   = bus.snk_startofpacket_i[gidx_q];
  assign g_eop   = bus.snk_endofpacket_i[gidx_q];
  assign g_data  = bus.snk_data_i[int'(gidx_q)*DWIDTH +: DWIDTH];

  // The MAX_PKT_LEN-th beat is always the last one the engine sees.
  assign at_max    = (beat_cnt_q == CW'(MAX_PKT_LEN - 1));
  assign in_xfer   = (state_q == FWD_IN) && g_valid && bus.eng_snk_ready_i;
  assign in_last   = in_xfer && (g_eop || at_max);
  assign force_eop = in_xfer && at_max && !g_eop;
  assign out_eop   = (state_q == WAIT_OUT) && bus.eng_src_valid_i &&
                     bus.src_ready_i[gidx_q] && bus.eng_src_endofpacket_i;
  assign drain_clr = (state_q == WAIT_OUT) && drain_q && g_valid && g_eop;
  assign exit_ok   = (state_q == WAIT_OUT) && (out_done_q || out_eop) &&
                     (!drain_q || drain_clr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pick_vld) state_d = FWD_IN;
      FWD_IN:   if (in_last)  state_d = WAIT_OUT;
      WAIT_OUT: if (exit_ok)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.snk_ready_o             = '0;
    bus.src_data_o              = '0;
    bus.src_valid_o             = '0;
    bus.src_startofpacket_o     = '0;
    bus.src_endofpacket_o       = '0;
    bus.eng_snk_data_o          = '0;
    bus.eng_snk_valid_o         = 1'b0;
    bus.eng_snk_startofpacket_o = 1'b0;
    bus.eng_snk_endofpacket_o   = 1'b0;
    bus.eng_src_ready_o         = 1'b0;
    bus.trunc_o                 = 1'b0;
    bus.drop_o                  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.snk_ready_o = stray;
        bus.drop_o      = |stray;
      end
      FWD_IN: begin
        bus.eng_snk_data_o          = g_data;
        bus.eng_snk_valid_o         = g_valid;
        bus.eng_snk_startofpacket_o = g_sop;
        bus.eng_snk_endofpacket_o   = g_eop || at_max;
        bus.snk_ready_o[gidx_q]     = bus.eng_snk_ready_i;
        bus.trunc_o                 = force_eop;
      end
      WAIT_OUT: begin
        bus.src_data_o[int'(gidx_q)*DWIDTH +: DWIDTH] = bus.eng_src_data_i;
        bus.src_valid_o[gidx_q]         = bus.eng_src_valid_i;
        bus.src_startofpacket_o[gidx_q] = bus.eng_src_startofpacket_i;
        bus.src_endofpacket_o[gidx_q]   = bus.eng_src_endofpacket_i;
        bus.eng_src_ready_o             = bus.src_ready_i[gidx_q];
        bus.snk_ready_o[gidx_q]         = drain_q;
      end
      default: ;
    endcase
    // Stray-beat acceptance is combinational, so hold it off while reset is asserted.
    if (arst_i) begin
      bus.snk_ready_o = '0;
      bus.drop_o      = 1'b0;
    end
  end

  assign bus.grant_o = grant_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      drain_q    <= 1'b0;
      out_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
          end
        end
        FWD_IN: begin
          if (in_xfer)   beat_cnt_q <= beat_cnt_q + CW'(1);
          if (force_eop) drain_q    <= 1'b1;
        end
        WAIT_OUT: begin
          if (drain_clr) drain_q <= 1'b0;
          if (exit_ok) begin
            grant_q    <= '0;
            beat_cnt_q <= '0;
            out_done_q <= 1'b0;
            rr_ptr_q   <= (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);
          end else if (out_eop) begin
            out_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_avalon_arbiter.sv
// tb/tb_sort_avalon_arbiter.sv - directed self-checking bench for sort_avalon_arbiter
module tb_sort_avalon_arbiter;
  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int MAXL = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sort_avalon_arbiter_if #(.N_REQ(N), .DWIDTH(DW)) bus ();

  sort_avalon_arbiter #(.N_REQ(N), .DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  beat_t         req_q[N][$];
  beat_t         got[N][$];
  beat_t         eng_log[$];
  logic [DW-1:0] eng_buf[$];
  beat_t         eng_out[$];
  logic          eng_pat[$];
  logic [N-1:0]  src_pat[$];
  int            grant_log[$];
  logic [N-1:0]  last_grant = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            trunc_cnt = 0;
  int            drop_cnt = 0;

  // Requester drivers, output monitors and a behavioural sorting engine.
  initial begin : driver
    beat_t         b;
    logic [N-1:0]  in_x;
    logic          eng_out_x, eng_eop_x;
    logic [DW-1:0] t;
    bus.snk_data_i = '0; bus.snk_valid_i = '0;
    bus.snk_startofpacket_i = '0; bus.snk_endofpacket_i = '0;
    bus.src_ready_i = '1; bus.eng_snk_ready_i = 1'b1;
    bus.eng_src_data_i = '0; bus.eng_src_valid_i = 1'b0;
    bus.eng_src_startofpacket_i = 1'b0; bus.eng_src_endofpacket_i = 1'b0;
    forever begin
      @(negedge clk_i);
      in_x = '0; eng_out_x = 1'b0; eng_eop_x = 1'b0;
      if (!arst_i) begin
        for (int r = 0; r < N; r++) begin
          in_x[r] = bus.snk_valid_i[r] & bus.snk_ready_o[r];
          if (bus.src_valid_o[r] && bus.src_ready_i[r]) begin
            b.data = bus.src_data_o[r*DW +: DW];
            b.sop  = bus.src_startofpacket_o[r];
            b.eop  = bus.src_endofpacket_o[r];
            got[r].push_back(b);
          end
        end
        if (bus.eng_snk_valid_o && bus.eng_snk_ready_i) begin
          b.data = bus.eng_snk_data_o;
          b.sop  = bus.eng_snk_startofpacket_o;
          b.eop  = bus.eng_snk_endofpacket_o;
          eng_log.push_back(b);
          eng_buf.push_back(b.data);
          eng_eop_x = b.eop;
        end
        eng_out_x = bus.eng_src_valid_i & bus.eng_src_ready_o;
        if (bus.trunc_o) trunc_cnt++;
        if (bus.drop_o) drop_cnt++;
        if (bus.grant_o != '0 && bus.grant_o != last_grant)
          for (int r = 0; r < N; r++) if (bus.grant_o[r]) grant_log.push_back(r);
        last_grant = bus.grant_o;
      end
      @(posedge clk_i);
      #1;
      if (arst_i) begin
        for (int r = 0; r < N; r++) begin
          req_q[r].delete();
          got[r].delete();
        end
        eng_log.delete(); eng_buf.delete(); eng_out.delete();
      end else begin
        for (int r = 0; r < N; r++)
          if (in_x[r] && req_q[r].size() > 0) b = req_q[r].pop_front();
        if (eng_out_x && eng_out.size() > 0) b = eng_out.pop_front();
        if (eng_eop_x) begin
          for (int i = 0; i < eng_buf.size(); i++)
            for (int j = 0; j < eng_buf.size() - 1 - i; j++)
              if (eng_buf[j] > eng_buf[j+1]) begin
                t = eng_buf[j]; eng_buf[j] = eng_buf[j+1]; eng_buf[j+1] = t;
              end
          for (int k = 0; k < eng_buf.size(); k++) begin
            b.data = eng_buf[k];
            b.sop  = (k == 0);
            b.eop  = (k == eng_buf.size() - 1);
            eng_out.push_back(b);
          end
          eng_buf.delete();
        end
      end
      for (int r = 0; r < N; r++) begin
        if (req_q[r].size() > 0) begin
          bus.snk_valid_i[r]         = 1'b1;
          bus.snk_data_i[r*DW +: DW] = req_q[r][0].data;
          bus.snk_startofpacket_i[r] = req_q[r][0].sop;
          bus.snk_endofpacket_i[r]   = req_q[r][0].eop;
        end else begin
          bus.snk_valid_i[r]         = 1'b0;
          bus.snk_data_i[r*DW +: DW] = '0;
          bus.snk_startofpacket_i[r] = 1'b0;
          bus.snk_endofpacket_i[r]   = 1'b0;
        end
      end
      if (eng_out.size() > 0) begin
        bus.eng_src_valid_i         = 1'b1;
        bus.eng_src_data_i          = eng_out[0].data;
        bus.eng_src_startofpacket_i = eng_out[0].sop;
        bus.eng_src_endofpacket_i   = eng_out[0].eop;
      end else begin
        bus.eng_src_valid_i         = 1'b0;
        bus.eng_src_data_i          = '0;
        bus.eng_src_startofpacket_i = 1'b0;
        bus.eng_src_endofpacket_i   = 1'b0;
      end
      if (eng_pat.size() > 0) bus.eng_snk_ready_i = eng_pat.pop_front();
      else                    bus.eng_snk_ready_i = 1'b1;
      if (src_pat.size() > 0) bus.src_ready_i = src_pat.pop_front();
      else                    bus.src_ready_i = '1;
    end
  end

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] v[8]);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = v[i];
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      req_q[r].push_back(b);
    end
  endtask

  task automatic wait_release(input int r, input int lim, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk_i);
      if (bus.grant_o[r]) seen = 1'b1;
      else if (seen && bus.grant_o == '0) ok = 1'b1;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.grant_o, bus.snk_ready_o, bus.src_valid_o, bus.src_endofpacket_o,
            bus.eng_snk_valid_o, bus.eng_snk_startofpacket_o, bus.eng_snk_endofpacket_o,
            bus.eng_src_ready_o, bus.trunc_o, bus.drop_o, 10'd0};
  endfunction

  task automatic test_reset();
    bit ok;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (all_outs() !== 32'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    #1 arst_i = 1'b0;
    push_pkt(0, 2, '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk_i);
      if (bus.grant_o == 4'b0001) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reset_pre_grant: got %b expected 0001", bus.grant_o); end
    @(posedge clk_i);
    #3 arst_i = 1'b1;
    #1;
    n_cmp++;
    if (all_outs() !== 32'd0 || bus.src_data_o !== '0 || bus.eng_snk_data_o !== '0) begin
      n_bad++; $display("FAIL reset_async: got %h expected 0", all_outs());
    end
    repeat (2) @(negedge clk_i);
    #1 arst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (eng_log.size() != 0 || bus.grant_o !== '0) begin
      n_bad++;
      $display("FAIL reset_abandon: got beats=%0d grant=%b expected 0/0", eng_log.size(), bus.grant_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok0, ok1, ok2;
    logic [DW-1:0] e0[5] = '{4'd4, 4'd5, 4'd1, 4'd6, 4'd7};
    logic          s0[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          f0[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] e2[3] = '{4'd8, 4'd9, 4'd10};
    @(negedge clk_i);
    #1;
    grant_log.delete();
    push_pkt(0, 2, '{4'd5, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    push_pkt(2, 3, '{4'd9, 4'd8, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    push_pkt(0, 3, '{4'd7, 4'd6, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    wait_release(0, 100, ok0);
    wait_release(2, 100, ok1);
    wait_release(0, 100, ok2);
    n_cmp++;
    if (!(ok0 && ok1 && ok2)) begin
      n_bad++; $display("FAIL rr_timeout: got %b%b%b expected 111", ok0, ok1, ok2);
    end
    n_cmp++;
    if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 2 || grant_log[2] != 0) begin
      n_bad++; $display("FAIL rr_order: got %p expected '{0,2,0}", grant_log);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= got[0].size() || got[0][k] !== {e0[k], s0[k], f0[k]}) begin
        n_bad++; $display("FAIL rr_req0_beat%0d: got %p expected %h/%b/%b", k, got[0], e0[k], s0[k], f0[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (k >= got[2].size() || got[2][k] !== {e2[k], k == 0, k == 2}) begin
        n_bad++; $display("FAIL rr_req2_beat%0d: got %p expected %h", k, got[2], e2[k]);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [DW-1:0] ei[3] = '{4'd3, 4'd1, 4'd2};
    @(negedge clk_i);
    #1;
    eng_log.delete();
    got[1].delete();
    push_pkt(1, 3, '{4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    @(negedge clk_i);
    n_cmp++;
    if (bus.grant_o !== 4'b0000 || bus.snk_valid_i[1] !== 1'b1 || bus.snk_ready_o[1] !== 1'b0) begin
      n_bad++; $display("FAIL single_arb_cycle: got grant=%b ready=%b expected 0000/0", bus.grant_o, bus.snk_ready_o[1]);
    end
    @(negedge clk_i);
    n_cmp++;
    if (bus.grant_o !== 4'b0010) begin
      n_bad++; $display("FAIL single_grant: got %b expected 0010", bus.grant_o);
    end
    wait_release(1, 60, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_timeout: got grant=%b expected release", bus.grant_o); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (k >= eng_log.size() || eng_log[k] !== {ei[k], k == 0, k == 2}) begin
        n_bad++; $display("FAIL single_eng_in%0d: got %p expected %h", k, eng_log, ei[k]);
      end
      n_cmp++;
      if (k >= got[1].size() || got[1][k] !== {DW'(k + 1), k == 0, k == 2}) begin
        n_bad++; $display("FAIL single_out%0d: got %p expected %0d", k, got[1], k + 1);
      end
    end
  endtask

  task automatic test_truncate();
    bit ok;
    int t0, d0;
    @(negedge clk_i);
    #1;
    eng_log.delete();
    got[3].delete();
    t0 = trunc_cnt;
    d0 = drop_cnt;
    for (int i = 0; i < 15; i++) src_pat.push_back(4'b0000);
    push_pkt(3, 7, '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
    wait_release(3, 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL trunc_timeout: got grant=%b expected release", bus.grant_o); end
    n_cmp++;
    if (got[3].size() != 5) begin
      n_bad++; $display("FAIL trunc_exit_early: got %0d out beats expected 5", got[3].size());
    end
    n_cmp++;
    if (trunc_cnt - t0 != 1 || drop_cnt - d0 != 0) begin
      n_bad++; $display("FAIL trunc_pulses: got trunc=%0d drop=%0d expected 1/0", trunc_cnt - t0, drop_cnt - d0);
    end
    n_cmp++;
    if (req_q[3].size() != 0) begin
      n_bad++; $display("FAIL trunc_drain: got %0d left expected 0", req_q[3].size());
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= eng_log.size() || eng_log[k] !== {DW'(7 - k), k == 0, k == 4}) begin
        n_bad++; $display("FAIL trunc_eng_in%0d: got %p expected %0d", k, eng_log, 7 - k);
      end
      n_cmp++;
      if (k >= got[3].size() || got[3][k] !== {DW'(3 + k), k == 0, k == 4}) begin
        n_bad++; $display("FAIL trunc_out%0d: got %p expected %0d", k, got[3], 3 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [DW-1:0] ei[4] = '{4'd9, 4'd2, 4'd7, 4'd4};
    logic [DW-1:0] eo[4] = '{4'd2, 4'd4, 4'd7, 4'd9};
    @(negedge clk_i);
    #1;
    eng_log.delete();
    got[1].delete();
    eng_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    src_pat = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'h0, 4'h0};
    push_pkt(1, 4, '{4'd9, 4'd2, 4'd7, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0});
    wait_release(1, 80, ok);
    n_cmp++;
    if (!ok || eng_log.size() != 4 || got[1].size() != 4) begin
      n_bad++; $display("FAIL bp_counts: got in=%0d out=%0d expected 4/4", eng_log.size(), got[1].size());
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= eng_log.size() || eng_log[k] !== {ei[k], k == 0, k == 3}) begin
        n_bad++; $display("FAIL bp_eng_in%0d: got %p expected %h", k, eng_log, ei[k]);
      end
      n_cmp++;
      if (k >= got[1].size() || got[1][k] !== {eo[k], k == 0, k == 3}) begin
        n_bad++; $display("FAIL bp_out%0d: got %p expected %h", k, got[1], eo[k]);
      end
    end
  endtask

  task automatic test_stray();
    beat_t b;
    int d0;
    @(negedge clk_i);
    #1;
    d0 = drop_cnt;
    b.data = 4'd5; b.sop = 1'b0; b.eop = 1'b0;
    req_q[1].push_back(b);
    @(negedge clk_i);
    n_cmp++;
    if (bus.snk_ready_o !== 4'b0010 || bus.drop_o !== 1'b1 || bus.grant_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL stray_accept: got ready=%b drop=%b grant=%b expected 0010/1/0000", bus.snk_ready_o, bus.drop_o, bus.grant_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (bus.grant_o !== 4'b0000 || bus.snk_valid_i[1] !== 1'b0 || bus.drop_o !== 1'b0 || drop_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL stray_after: got grant=%b valid=%b drops=%0d expected 0000/0/1", bus.grant_o, bus.snk_valid_i[1], drop_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_truncate();
    test_back_to_back();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
